mc_controller: RTL and testbench

- Multicycle successor to the single-cycle main decoder: a Moore/Mealy FSM that sequences each MIPS instruction over 3–5 cycles through one shared ALU and one shared memory.
- Adds memory wait-state handshaking and BNE/ANDI/ORI support.
- Driven by the instruction-register opcode and the ALU zero flag; drives datapath muxes, write enables and the ALU-decoder aluop.

---
 rtl/mc_ctrl_pkg.sv | 50 +++++
 rtl/mc_ctrl_outdec.sv | 114 +++++++++++
 rtl/mc_controller.sv | 130 +++++++++++++
 tb/tb_mc_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcodes, ALU-decoder operation codes and datapath mux encodings.
package mc_ctrl_pkg;

    localparam int MC_STATE_W = 4;

    typedef enum logic [MC_STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        BNEEX   = 4'd9,
        ADDIEX  = 4'd10,
        LOGIEX  = 4'd11,
        IMMWB   = 4'd12,
        JEX     = 4'd13,
        TRAP    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State-to-control decoder for mc_controller. Purely combinational; every
// output here depends on the current state only (op merely selects and/or
// in LOGIEX, and op is stable from DECODE onward).
// Build option: MC_ILLEGAL_TRAP_EN adds the TRAP state decode (illegal=1).
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic [OP_W-1:0]    op,
    output logic               in_fetch,
    output logic               pcwrite_st,
    output logic               branch,
    output logic               branchbne,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic               immext,
    output logic               illegal
);

    function automatic logic [STATE_W-1:0] st(input state_t s);
        return STATE_W'(s);
    endfunction

    // Decode the current state into datapath controls; unlisted controls stay 0, aluop stays add
    always_comb begin
        in_fetch   = 1'b0;
        pcwrite_st = 1'b0;
        branch     = 1'b0;
        branchbne  = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_W'(ALU_ADD);
        immext     = 1'b0;
        illegal    = 1'b0;
        case (state)
            st(FETCH): begin
                in_fetch = 1'b1;
                memread  = 1'b1;
                alusrcb  = SRCB_FOUR;
            end
            st(DECODE): alusrcb = SRCB_IMMSH;
            st(MEMADR): begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            st(MEMRD): begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            st(MEMWB): begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            st(MEMWR): begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            st(RTYPEEX): begin
                alusrca = 1'b1;
                aluop   = ALUOP_W'(ALU_FUNCT);
            end
            st(ALUWB): begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            st(BEQEX), st(BNEEX): begin
                alusrca   = 1'b1;
                aluop     = ALUOP_W'(ALU_SUB);
                pcsrc     = PCSRC_ALUOUT;
                branch    = (state == st(BEQEX));
                branchbne = (state == st(BNEEX));
            end
            st(ADDIEX): begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            st(LOGIEX): begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                immext  = 1'b1;
                aluop   = (op == OP_W'(OP_ORI)) ? ALUOP_W'(ALU_OR) : ALUOP_W'(ALU_AND);
            end
            st(IMMWB): regwrite = 1'b1;
            st(JEX): begin
                pcsrc      = PCSRC_JUMP;
                pcwrite_st = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            st(TRAP): illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: sequences each instruction over 3-5
// cycles with memory wait states. pcen and irwrite are the only outputs
// that react combinationally to zero/mem_ready; the rest follow the state.
// Build option: MC_ILLEGAL_TRAP_EN sends unknown opcodes to a sticky TRAP
// state; otherwise they fall back to FETCH as a 2-cycle NOP.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcen,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic               immext,
    output logic               illegal
);

    function automatic logic [STATE_W-1:0] st(input state_t s);
        return STATE_W'(s);
    endfunction

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               in_fetch;
    logic               pcwrite_st;
    logic               branch;
    logic               branchbne;
    logic               pcwrite;

    // Next-state sequencing; unreachable encodings recover to FETCH
    always_comb begin
        state_d = st(FETCH);
        case (state_q)
            st(FETCH):   state_d = mem_ready ? st(DECODE) : st(FETCH);
            st(DECODE): begin
                case (op)
                    OP_W'(OP_LW), OP_W'(OP_SW):   state_d = st(MEMADR);
                    OP_W'(OP_RTYPE):              state_d = st(RTYPEEX);
                    OP_W'(OP_BEQ):                state_d = st(BEQEX);
                    OP_W'(OP_BNE):                state_d = st(BNEEX);
                    OP_W'(OP_ADDI):               state_d = st(ADDIEX);
                    OP_W'(OP_ANDI), OP_W'(OP_ORI): state_d = st(LOGIEX);
                    OP_W'(OP_J):                  state_d = st(JEX);
`ifdef MC_ILLEGAL_TRAP_EN
                    default:                      state_d = st(TRAP);
`else
                    default:                      state_d = st(FETCH);
`endif
                endcase
            end
            st(MEMADR): begin
                if (op == OP_W'(OP_LW)) begin
                    state_d = st(MEMRD);
                end else if (op == OP_W'(OP_SW)) begin
                    state_d = st(MEMWR);
                end else begin
                    state_d = st(FETCH);
                end
            end
            st(MEMRD):   state_d = mem_ready ? st(MEMWB) : st(MEMRD);
            st(MEMWR):   state_d = mem_ready ? st(FETCH) : st(MEMWR);
            st(RTYPEEX): state_d = st(ALUWB);
            st(ADDIEX),
            st(LOGIEX):  state_d = st(IMMWB);
`ifdef MC_ILLEGAL_TRAP_EN
            st(TRAP):    state_d = st(TRAP);
`endif
            default:     state_d = st(FETCH);
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= st(FETCH);
        end else begin
            state_q <= state_d;
        end
    end

    mc_ctrl_outdec #(
        .ALUOP_W (ALUOP_W),
        .OP_W    (OP_W),
        .STATE_W (STATE_W)
    ) u_outdec (
        .state      (state_q),
        .op         (op),
        .in_fetch   (in_fetch),
        .pcwrite_st (pcwrite_st),
        .branch     (branch),
        .branchbne  (branchbne),
        .iord       (iord),
        .memread    (memread),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .immext     (immext),
        .illegal    (illegal)
    );

    // Mealy enables: fetch completes only on mem_ready, branches follow zero,
    // and nothing may write while reset is held
    always_comb begin
        pcwrite = pcwrite_st | (in_fetch & mem_ready);
        irwrite = ~reset & in_fetch & mem_ready;
        pcen    = ~reset & (pcwrite | (branch & zero) | (branchbne & ~zero));
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by
// cycle and compares all outputs against hand-derived per-state vectors.
// Honors MC_ILLEGAL_TRAP_EN to pick the expected illegal-opcode behaviour.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pcen, iord, memread, memwrite, irwrite, regwrite;
    logic       regdst, memtoreg, alusrca, immext, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluop;

    int nVectors    = 0;
    int nMiscompares = 0;

    mc_controller #(.ALUOP_W(3), .OP_W(6), .STATE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pcen      (pcen),
        .iord      (iord),
        .memread   (memread),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regwrite  (regwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .aluop     (aluop),
        .immext    (immext),
        .illegal   (illegal)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Field order: iord memread memwrite irwrite regwrite regdst memtoreg
    // alusrca alusrcb pcsrc aluop immext illegal pcen
    function automatic logic [17:0] mk(
        input logic a_iord, input logic a_mrd, input logic a_mwr, input logic a_irw,
        input logic a_rw, input logic a_rd, input logic a_m2r, input logic a_sa,
        input logic [1:0] a_sb, input logic [1:0] a_pcs, input logic [2:0] a_op,
        input logic a_ext, input logic a_ill, input logic a_pcen);
        return {a_iord, a_mrd, a_mwr, a_irw, a_rw, a_rd, a_m2r, a_sa,
                a_sb, a_pcs, a_op, a_ext, a_ill, a_pcen};
    endfunction

    localparam logic [17:0] E_FETCH_GO   = mk(0,1,0,1,0,0,0,0,2'b01,2'b00,3'b000,0,0,1);
    localparam logic [17:0] E_FETCH_WAIT = mk(0,1,0,0,0,0,0,0,2'b01,2'b00,3'b000,0,0,0);
    localparam logic [17:0] E_DECODE     = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0,0,0);
    localparam logic [17:0] E_MEMADR     = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0,0,0);
    localparam logic [17:0] E_MEMRD      = mk(1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,0);
    localparam logic [17:0] E_MEMWB      = mk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,0,0);
    localparam logic [17:0] E_MEMWR      = mk(1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,0);
    localparam logic [17:0] E_RTYPE      = mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0,0,0);
    localparam logic [17:0] E_ALUWB      = mk(0,0,0,0,1,1,0,0,2'b00,2'b00,3'b000,0,0,0);
    localparam logic [17:0] E_BR_TAKEN   = mk(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001,0,0,1);
    localparam logic [17:0] E_BR_NOT     = mk(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001,0,0,0);
    localparam logic [17:0] E_ADDI       = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0,0,0);
    localparam logic [17:0] E_ORI        = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b011,1,0,0);
    localparam logic [17:0] E_ANDI       = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,1,0,0);
    localparam logic [17:0] E_IMMWB      = mk(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000,0,0,0);
    localparam logic [17:0] E_JEX        = mk(0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,0,1);
    localparam logic [17:0] E_TRAP       = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,1,0);

    task automatic applyStimulus(input logic [5:0] a_op, input logic a_zero, input logic a_ready);
        op        = a_op;
        zero      = a_zero;
        mem_ready = a_ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [17:0] expected);
        logic [17:0] observed;
        observed = {iord, memread, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
                    alusrcb, pcsrc, aluop, immext, illegal, pcen};
        nVectors++;
        assert (observed === expected) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, move on
    task automatic runStep(input string tag, input logic [5:0] a_op, input logic a_zero,
                           input logic a_ready, input logic [17:0] expected);
        applyStimulus(a_op, a_zero, a_ready);
        checkOutput(tag, expected);
        @(negedge clk);
    endtask

    // Directed sequence covering every instruction class and the corner cases
    initial begin
        reset     = 1'b1;
        op        = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #1;
        checkOutput("reset_state", E_FETCH_WAIT);
        @(negedge clk);
        reset = 1'b0;

        // Fetch wait state, then lw with no memory waits (5 cycles)
        runStep("fetch_wait",   6'b100011, 0, 0, E_FETCH_WAIT);
        runStep("lw_fetch",     6'b100011, 0, 1, E_FETCH_GO);
        runStep("lw_decode",    6'b100011, 0, 1, E_DECODE);
        runStep("lw_memadr",    6'b100011, 0, 1, E_MEMADR);
        runStep("lw_memrd",     6'b100011, 0, 1, E_MEMRD);
        runStep("lw_memwb",     6'b100011, 0, 1, E_MEMWB);

        // sw with three wait cycles in MEMWR
        runStep("sw_fetch",     6'b101011, 0, 1, E_FETCH_GO);
        runStep("sw_decode",    6'b101011, 0, 1, E_DECODE);
        runStep("sw_memadr",    6'b101011, 0, 1, E_MEMADR);
        runStep("sw_wait1",     6'b101011, 0, 0, E_MEMWR);
        runStep("sw_wait2",     6'b101011, 0, 0, E_MEMWR);
        runStep("sw_wait3",     6'b101011, 0, 0, E_MEMWR);
        runStep("sw_done",      6'b101011, 0, 1, E_MEMWR);

        // Another sw, aborted by reset while MEMWR is waiting
        runStep("sw2_fetch",    6'b101011, 0, 1, E_FETCH_GO);
        runStep("sw2_decode",   6'b101011, 0, 1, E_DECODE);
        runStep("sw2_memadr",   6'b101011, 0, 1, E_MEMADR);
        applyStimulus(6'b101011, 0, 0);
        checkOutput("sw2_memwr", E_MEMWR);
        #2;
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        checkOutput("reset_mid_memwr", E_FETCH_WAIT);
        @(negedge clk);
        reset = 1'b0;

        // bne not-taken zero / taken zero, then beq with zero
        runStep("bne0_fetch",   6'b000101, 0, 1, E_FETCH_GO);
        runStep("bne0_decode",  6'b000101, 0, 1, E_DECODE);
        runStep("bne0_ex",      6'b000101, 0, 1, E_BR_TAKEN);
        runStep("bne1_fetch",   6'b000101, 1, 1, E_FETCH_GO);
        runStep("bne1_decode",  6'b000101, 1, 1, E_DECODE);
        runStep("bne1_ex",      6'b000101, 1, 1, E_BR_NOT);
        runStep("beq1_fetch",   6'b000100, 1, 1, E_FETCH_GO);
        runStep("beq1_decode",  6'b000100, 1, 1, E_DECODE);
        runStep("beq1_ex",      6'b000100, 1, 1, E_BR_TAKEN);
        runStep("beq0_fetch",   6'b000100, 0, 1, E_FETCH_GO);
        runStep("beq0_decode",  6'b000100, 0, 1, E_DECODE);
        runStep("beq0_ex",      6'b000100, 0, 1, E_BR_NOT);

        // Immediate logic and arithmetic
        runStep("ori_fetch",    6'b001101, 0, 1, E_FETCH_GO);
        runStep("ori_decode",   6'b001101, 0, 1, E_DECODE);
        runStep("ori_ex",       6'b001101, 0, 1, E_ORI);
        runStep("ori_wb",       6'b001101, 0, 1, E_IMMWB);
        runStep("andi_fetch",   6'b001100, 0, 1, E_FETCH_GO);
        runStep("andi_decode",  6'b001100, 0, 1, E_DECODE);
        runStep("andi_ex",      6'b001100, 0, 1, E_ANDI);
        runStep("andi_wb",      6'b001100, 0, 1, E_IMMWB);
        runStep("addi_fetch",   6'b001000, 0, 1, E_FETCH_GO);
        runStep("addi_decode",  6'b001000, 0, 1, E_DECODE);
        runStep("addi_ex",      6'b001000, 0, 1, E_ADDI);
        runStep("addi_wb",      6'b001000, 0, 1, E_IMMWB);

        // R-type and jump
        runStep("rtype_fetch",  6'b000000, 0, 1, E_FETCH_GO);
        runStep("rtype_decode", 6'b000000, 0, 1, E_DECODE);
        runStep("rtype_ex",     6'b000000, 0, 1, E_RTYPE);
        runStep("rtype_wb",     6'b000000, 0, 1, E_ALUWB);
        runStep("j_fetch",      6'b000010, 0, 1, E_FETCH_GO);
        runStep("j_decode",     6'b000010, 0, 1, E_DECODE);
        runStep("j_ex",         6'b000010, 0, 1, E_JEX);

        // Unknown opcode
        runStep("ill_fetch",    6'b111111, 0, 1, E_FETCH_GO);
        runStep("ill_decode",   6'b111111, 0, 1, E_DECODE);
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            runStep($sformatf("ill_trap%0d", i), 6'b111111, 0, 1, E_TRAP);
        end
        reset = 1'b1;
        #1;
        checkOutput("trap_reset", E_FETCH_WAIT);
        @(negedge clk);
        reset = 1'b0;
        runStep("post_trap_fetch", 6'b000000, 0, 1, E_FETCH_GO);
`else
        runStep("ill_back_fetch", 6'b111111, 0, 1, E_FETCH_GO);
        runStep("ill_next_decode", 6'b111111, 0, 1, E_DECODE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
